// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode and output-stage enums, opcode legality check.
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int OP_W   = 3;
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5
    } alu_op_e;
    typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester channels and response channel of the shared ALU.
// slave modport is the arbiter side, master modport is the client side.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_opcode;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_err;
    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational 16-bit ALU (ADD, SUB, AND, OR, XOR, NOT A).
// Ports: clk, rst_n (tied off, no state), i_op opcode, i_a/i_b operands, o_y result.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    always_comb
        o_y = (i_op == OP_ADD) ? i_a + i_b :
              (i_op == OP_SUB) ? i_a - i_b :
              (i_op == OP_AND) ? i_a & i_b :
              (i_op == OP_OR)  ? i_a | i_b :
              (i_op == OP_XOR) ? i_a ^ i_b :
              (i_op == OP_NOT) ? ~i_a      : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NUM_REQ requesters with a registered response stage.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave: request and response channels).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    out_state_e          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr, r_id, w_grant;
    logic [DATA_W-1:0]   r_result, w_alu_y;
    logic                r_err, w_found, w_can_accept, w_accept, w_legal;
    logic [ID_W:0]       w_pick;
    logic [NUM_REQ-1:0]  w_ready;
    logic [OP_W-1:0]     w_op;
    // {found, index}: scan downward so the lowest offset from the pointer wins
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] p);
        logic [ID_W:0] r;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (v[(int'(p) + k) % NUM_REQ]) r = {1'b1, ID_W'((int'(p) + k) % NUM_REQ)};
        return r;
    endfunction
    assign w_pick       = rr_pick(bus.req_valid, r_rr_ptr);
    assign w_found      = w_pick[ID_W];
    assign w_grant      = w_pick[ID_W-1:0];
    assign w_can_accept = (r_state == ST_EMPTY) || bus.rsp_ready;
    // rst_n gating keeps req_ready low during reset, not just after the first edge
    assign w_ready      = (rst_n && w_found && w_can_accept) ? (NUM_REQ'(1) << w_grant) : '0;
    assign w_accept     = |(bus.req_valid & w_ready);
    assign w_op         = bus.req_opcode[w_grant*OP_W +: OP_W];
    assign w_legal      = is_legal_op(w_op);
    alu u_alu (
        .clk   (clk),
        .rst_n (rst_n),
        .i_op  (w_op),
        .i_a   (bus.req_a[w_grant*DATA_W +: DATA_W]),
        .i_b   (bus.req_b[w_grant*DATA_W +: DATA_W]),
        .o_y   (w_alu_y)
    );
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) w_state_nxt = ST_FULL;
        else if (bus.rsp_ready) w_state_nxt = ST_EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
                r_id     <= w_grant;
                r_result <= w_legal ? w_alu_y : '0;
                r_err    <= !w_legal;
            end
        end
    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = (r_state == ST_FULL);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_err    = r_err;
endmodule
